// File: rtl/sram_arbiter_if.sv
// Request/response bundle between the two masters, the arbiter and the SRAM controller.
// The slave view is the arbiter: it takes requests and mem_ready, and drives the controller side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m1_req;
  logic              m0_we;
  logic              m1_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_done;
  logic              m1_done;
  logic              m0_err;
  logic              m1_err;
  logic [DATA_W-1:0] rdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_ready, mem_rdata,
    output m0_done, m1_done, m0_err, m1_err, rdata,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_ready, mem_rdata,
    input  m0_done, m1_done, m0_err, m1_err, rdata,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the SRAM controller.
// One access at a time: IDLE grants, ISSUE holds the controller bus until ready or timeout, DONE pulses.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 31
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that did not win last time goes; otherwise the sole requester.
  assign winner    = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
  assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          grant_d = winner;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wr_en_d = sel_we;
          rd_en_d = ~sel_we;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.mem_ready) begin
          rd_en_d         = 1'b0;
          wr_en_d         = 1'b0;
          if (rd_en_q) rdata_d = bus.mem_rdata;
          done_d[grant_q] = 1'b1;
          last_d          = grant_q;
          state_d         = StDone;
        end else if (cnt_q == CNT_LAST) begin
          rd_en_d         = 1'b0;
          wr_en_d         = 1'b0;
          rdata_d         = '0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          last_d          = grant_q;
          state_d         = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Enforces an idle-enable cycle so the controller can re-arm.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer in front of the SRAM controller. It accepts 32-bit read/write requests from two masters (port 0: pipeline MEM stage, port 1: secondary master such as a cache-fill or DMA engine). It serialises the requests onto the controller's rd_en/wr_en/address/write_data interface and holds them stable until the controller's ready. It then returns read data and a one-cycle done pulse to the granted master, and aborts with an error if ready never arrives.

## Interface
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width
- TIMEOUT, 31, max cycles in ISSUE before abort (≥ 7)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req, m1_req  in  1  request; held high with attributes stable until the matching done
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  byte address, passed through unmodified
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_done, m1_done  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid with done; 1 = timed out
- rdata  out  DATA_W  read data, valid with done, shared by both ports
- mem_rd_en, mem_wr_en  out  1  controller enables, never both high
- mem_addr  out  ADDR_W  controller address
- mem_wdata  out  DATA_W  controller write data
- mem_ready  in  1  controller ready; only meaningful while an enable is high
- mem_rdata  in  DATA_W  controller read data

## Operation
- All outputs are registered. Reset values are 0, including rdata and mem_*. The FSM resets to IDLE and the last-grant pointer resets to 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any req is high at the edge, select a winner.
  - With both requesting, the winner is the port not equal to the last-grant pointer. Otherwise the winner is the sole requester.
  - Load mem_addr/mem_wdata from the winner. Set mem_wr_en = we and mem_rd_en = ~we.
  - Record grant, clear the timeout counter, go to ISSUE.
- ISSUE:
  - Enables, address and data are held constant.
  - mem_ready is sampled only in this state. mem_ready = 1 while idle is ignored, because the controller reports ready when not enabled.
  - On an edge with mem_ready = 1:
    - Drop both enables.
    - For a read, capture rdata <= mem_rdata. For a write, rdata keeps its value.
    - Set the granted port's done = 1 and err = 0. Update last-grant. Go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without ready:
    - Drop enables and set rdata <= 0.
    - Set the granted port's done = 1 and err = 1. Update last-grant. Go to DONE.
- DONE:
  - done/err are high for exactly this cycle, then cleared. Go to IDLE unconditionally.
  - A new request cannot be granted in DONE. Enables are therefore low for at least one full cycle between accesses, which lets the controller return to its idle count.
- Requester rule: a master deasserts req (or presents a new request) at the edge ending its done cycle. A request still high in IDLE is treated as new.
- Req dropped mid-ISSUE: ignored. The access completes and done still pulses.
- The non-granted port's req is simply held off; there is no queueing beyond the req line.

## Timing
- The controller needs 6 enabled cycles, with ready high in the 6th.
- Read or write, req sampled at edge E0:
  - Enables go high in cycles 1–6.
  - Ready is seen at edge E6.
  - done and rdata are valid in cycle 7 (DONE).
  - IDLE is cycle 8.
- Throughput is one access per 8 cycles.
- Both ports continuously requesting alternate strictly: 0,1,0,1…
- Timeout: done with err in cycle TIMEOUT+1 after the request edge.
- rst mid-access:
  - All outputs clear immediately. No done pulse is issued and the pending request is lost.
  - The masters must re-request.

## Test plan
- Reset, then m0 read addr 0x100, mem_rdata = 0xDEADBEEF at ready -> mem_rd_en high for cycles 1–6, m0_done = 1 with rdata = 0xDEADBEEF and m0_err = 0 in cycle 7, m1_done stays 0.
- m1 write addr 0x204 data 0x12345678 -> mem_wr_en = 1, mem_rd_en = 0, mem_addr = 0x204 and mem_wdata = 0x12345678 stable for 6 cycles, m1_done in cycle 7, rdata unchanged.
- m0 and m1 both requesting from reset, held continuously -> grant order 0,1,0,1 with done pulses 8 cycles apart, and at least one idle-enable cycle between accesses.
- mem_ready tied high while idle, no requests -> no done pulses and enables stay 0.
- mem_ready stuck low, m0 read, TIMEOUT = 31 -> enables drop, m0_done = 1, m0_err = 1, rdata = 0 at cycle 32. The next m1 request is then serviced normally.
- rst asserted in cycle 3 of an m1 read -> all outputs 0 asynchronously and no m1_done. After release, m0 wins a simultaneous request.
